// File: rtl/issue_queue_if.sv
// Fetch-side and register-read-side signals of the dual-issue instruction queue.
// The queue is the slave; fetch and the register stage together act as master.
interface issue_queue_if #(
    parameter int AW = 3
);
    logic          in_valid;
    logic [31:0]   in_ins0;
    logic [31:0]   in_ins1;
    logic [31:0]   in_pc;
    logic          in_ready;
    logic          flush;
    logic          out_ready;
    logic          out_valid0;
    logic          out_valid1;
    logic [31:0]   out_ins0;
    logic [31:0]   out_ins1;
    logic [31:0]   out_pc0;
    logic [31:0]   out_pc1;
    logic [AW:0]   count;
    logic          overflow;

    // Handshakes: a fetch pair transfers on an edge where in_valid && in_ready;
    // the issue register is consumed on an edge where out_ready is high, and
    // refills whenever it is consumed or empty (out_valid0 low).
    modport slave (
        input  in_valid, in_ins0, in_ins1, in_pc, flush, out_ready,
        output in_ready, out_valid0, out_valid1, out_ins0, out_ins1,
               out_pc0, out_pc1, count, overflow
    );

    modport master (
        output in_valid, in_ins0, in_ins1, in_pc, flush, out_ready,
        input  in_ready, out_valid0, out_valid1, out_ins0, out_ins1,
               out_pc0, out_pc1, count, overflow
    );
endinterface

// File: rtl/issue_queue.sv
// Dual-issue instruction queue: circular buffer of fetched pairs feeding a
// two-lane issue register with control and RAW/WAW pairing restrictions.
module issue_queue #(
    parameter int DEPTH = 8,
    parameter int AW    = 3
) (
    input  logic           clk,
    input  logic           rst,
    issue_queue_if.slave   bus
);
    localparam logic [5:0] OP_SPECIAL = 6'b000000;
    localparam logic [5:0] OP_J       = 6'b000010;
    localparam logic [5:0] OP_JAL     = 6'b000011;
    localparam logic [5:0] OP_BEQ     = 6'b000100;
    localparam logic [5:0] OP_ADDI    = 6'b001000;
    localparam logic [5:0] OP_LW      = 6'b100011;
    localparam logic [5:0] OP_SW      = 6'b101011;
    localparam logic [5:0] FN_JR      = 6'b001000;

    logic [31:0]  mem_ins_q [DEPTH];
    logic [31:0]  mem_pc_q  [DEPTH];
    logic [AW-1:0] head_q, head_d, tail_q, tail_d;
    logic [AW:0]   count_q, count_d;
    logic          overflow_q, overflow_d;
    logic          out_valid0_q, out_valid0_d, out_valid1_q, out_valid1_d;
    logic [31:0]   out_ins0_q, out_ins0_d, out_ins1_q, out_ins1_d;
    logic [31:0]   out_pc0_q, out_pc0_d, out_pc1_q, out_pc1_d;

    function automatic logic is_ctrl(input logic [5:0] op, input logic [5:0] fn);
        return (op == OP_JAL) || (op == OP_J) || (op == OP_BEQ) ||
               (op == OP_SPECIAL && fn == FN_JR);
    endfunction

    // Register 0 doubles as "no destination": it never creates a hazard.
    function automatic logic [4:0] dest_of(input logic [5:0] op, input logic [5:0] fn,
                                           input logic [4:0] rt, input logic [4:0] rd);
        logic [4:0] d;
        d = 5'd0;
        if (op == OP_SPECIAL && fn != FN_JR) d = rd;
        else if (op == OP_ADDI || op == OP_LW) d = rt;
        else if (op == OP_JAL) d = 5'd31;
        return d;
    endfunction

    logic [AW-1:0] head_p1, tail_p1;
    logic [31:0]   h_ins, n_ins, h_pc, n_pc;
    logic [4:0]    h_dest, n_dest;
    logic          n_uses_rt, raw, waw, lane0, lane1, load, enq;
    logic [AW:0]   pop_cnt, enq_cnt;

    assign head_p1 = head_q + AW'(1);
    assign tail_p1 = tail_q + AW'(1);
    assign h_ins   = mem_ins_q[head_q];
    assign n_ins   = mem_ins_q[head_p1];
    assign h_pc    = mem_pc_q[head_q];
    assign n_pc    = mem_pc_q[head_p1];

    assign h_dest    = dest_of(h_ins[31:26], h_ins[5:0], h_ins[20:16], h_ins[15:11]);
    assign n_dest    = dest_of(n_ins[31:26], n_ins[5:0], n_ins[20:16], n_ins[15:11]);
    assign n_uses_rt = (n_ins[31:26] == OP_SPECIAL) || (n_ins[31:26] == OP_BEQ) ||
                       (n_ins[31:26] == OP_SW);
    assign raw = (h_dest != 5'd0) &&
                 ((h_dest == n_ins[25:21]) || (n_uses_rt && h_dest == n_ins[20:16]));
    assign waw = (h_dest != 5'd0) && (h_dest == n_dest);

    assign lane0 = (count_q != '0);
    assign lane1 = (count_q >= (AW+1)'(2)) && !is_ctrl(h_ins[31:26], h_ins[5:0]) &&
                   !is_ctrl(n_ins[31:26], n_ins[5:0]) && !raw && !waw;
    assign load  = !out_valid0_q || bus.out_ready;

    // in_ready looks only at the registered count, never at same-edge pops.
    assign bus.in_ready = (count_q <= (AW+1)'(DEPTH - 2));
    assign enq          = bus.in_valid && bus.in_ready;

    always_comb begin
        pop_cnt      = '0;
        enq_cnt      = enq ? (AW+1)'(2) : '0;
        out_valid0_d = out_valid0_q;
        out_valid1_d = out_valid1_q;
        out_ins0_d   = out_ins0_q;
        out_ins1_d   = out_ins1_q;
        out_pc0_d    = out_pc0_q;
        out_pc1_d    = out_pc1_q;
        overflow_d   = overflow_q || (bus.in_valid && !bus.in_ready);
        if (load) begin
            pop_cnt      = (AW+1)'(lane0) + (AW+1)'(lane0 && lane1);
            out_valid0_d = lane0;
            out_valid1_d = lane0 && lane1;
            out_ins0_d   = lane0 ? h_ins : 32'd0;
            out_pc0_d    = lane0 ? h_pc  : 32'd0;
            out_ins1_d   = (lane0 && lane1) ? n_ins : 32'd0;
            out_pc1_d    = (lane0 && lane1) ? n_pc  : 32'd0;
        end
        head_d  = head_q + pop_cnt[AW-1:0];
        tail_d  = enq ? tail_q + AW'(2) : tail_q;
        count_d = count_q + enq_cnt - pop_cnt;
    end

    always_ff @(posedge clk) begin
        if (rst && !bus.flush && enq) begin
            mem_ins_q[tail_q]  <= bus.in_ins0;
            mem_pc_q[tail_q]   <= bus.in_pc;
            mem_ins_q[tail_p1] <= bus.in_ins1;
            mem_pc_q[tail_p1]  <= bus.in_pc + 32'd1;
        end
    end

    // Flush keeps overflow: it records a fetch protocol error, not queue content.
    always_ff @(posedge clk) begin
        if (!rst || bus.flush) begin
            head_q       <= '0;
            tail_q       <= '0;
            count_q      <= '0;
            out_valid0_q <= 1'b0;
            out_valid1_q <= 1'b0;
            out_ins0_q   <= '0;
            out_ins1_q   <= '0;
            out_pc0_q    <= '0;
            out_pc1_q    <= '0;
            overflow_q   <= rst ? overflow_q : 1'b0;
        end else begin
            head_q       <= head_d;
            tail_q       <= tail_d;
            count_q      <= count_d;
            out_valid0_q <= out_valid0_d;
            out_valid1_q <= out_valid1_d;
            out_ins0_q   <= out_ins0_d;
            out_ins1_q   <= out_ins1_d;
            out_pc0_q    <= out_pc0_d;
            out_pc1_q    <= out_pc1_d;
            overflow_q   <= overflow_d;
        end
    end

    assign bus.out_valid0 = out_valid0_q;
    assign bus.out_valid1 = out_valid1_q;
    assign bus.out_ins0   = out_ins0_q;
    assign bus.out_ins1   = out_ins1_q;
    assign bus.out_pc0    = out_pc0_q;
    assign bus.out_pc1    = out_pc1_q;
    assign bus.count      = count_q;
    assign bus.overflow   = overflow_q;
endmodule

// File: tb/tb_issue_queue.sv
// Directed bench for issue_queue: pairing rules, flush, back-pressure,
// overflow, pointer wrap with an in-order scoreboard, and mid-state reset.
module tb_issue_queue;
    localparam int DEPTH = 8;
    localparam int AW    = 3;

    localparam logic [31:0] ADD_3_1_2 = 32'h00221820;
    localparam logic [31:0] ADD_5_4_6 = 32'h00862820;
    localparam logic [31:0] ADD_6_3_1 = 32'h00613020;
    localparam logic [31:0] BEQ_1_2   = 32'h10220003;

    logic clk;
    logic rst;
    int   n_checks;
    int   n_errors;
    logic [63:0] exp_q[$];

    issue_queue_if #(.AW(AW)) bus ();

    issue_queue #(.DEPTH(DEPTH), .AW(AW)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    // clock / reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // driver tasks
    task automatic drive_pair(input logic [31:0] i0, input logic [31:0] i1, input logic [31:0] pc);
        bus.in_valid = 1'b1;
        bus.in_ins0  = i0;
        bus.in_ins1  = i1;
        bus.in_pc    = pc;
    endtask

    task automatic drive_idle();
        bus.in_valid = 1'b0;
        bus.in_ins0  = '0;
        bus.in_ins1  = '0;
        bus.in_pc    = '0;
    endtask

    task automatic do_reset();
        rst = 1'b0;
        tick();
        tick();
        rst = 1'b1;
    endtask

    // scoreboard: pop expected {ins,pc} for every occupied lane, in lane order
    task automatic consume_lane(input string tag, input logic v, input logic [31:0] ins,
                                input logic [31:0] pc);
        logic [63:0] e;
        if (v) begin
            if (exp_q.size() == 0) begin
                check({tag, "_unexpected"}, 32'd1, 32'd0);
            end else begin
                e = exp_q.pop_front();
                check({tag, "_ins"}, ins, e[63:32]);
                check({tag, "_pc"},  pc,  e[31:0]);
            end
        end
    endtask

    initial begin
        n_checks      = 0;
        n_errors      = 0;
        rst           = 1'b0;
        bus.flush     = 1'b0;
        bus.out_ready = 1'b0;
        drive_idle();
        do_reset();

        check("rst_count",    32'(bus.count),      32'd0);
        check("rst_in_ready", 32'(bus.in_ready),   32'd1);
        check("rst_valid0",   32'(bus.out_valid0), 32'd0);
        check("rst_overflow", 32'(bus.overflow),   32'd0);

        // independent pair issues dual two edges after fetch
        bus.out_ready = 1'b1;
        drive_pair(ADD_3_1_2, ADD_5_4_6, 32'h10);
        tick();
        drive_idle();
        check("t1_count_e1",  32'(bus.count),      32'd2);
        check("t1_valid0_e1", 32'(bus.out_valid0), 32'd0);
        tick();
        check("t1_valid0", 32'(bus.out_valid0), 32'd1);
        check("t1_valid1", 32'(bus.out_valid1), 32'd1);
        check("t1_pc0",    bus.out_pc0,         32'h10);
        check("t1_pc1",    bus.out_pc1,         32'h11);
        check("t1_ins0",   bus.out_ins0,        ADD_3_1_2);
        check("t1_ins1",   bus.out_ins1,        ADD_5_4_6);
        check("t1_count",  32'(bus.count),      32'd0);

        // RAW on $3 splits the pair
        drive_pair(ADD_3_1_2, ADD_6_3_1, 32'h20);
        tick();
        drive_idle();
        tick();
        check("t2_valid0", 32'(bus.out_valid0), 32'd1);
        check("t2_valid1", 32'(bus.out_valid1), 32'd0);
        check("t2_pc0",    bus.out_pc0,         32'h20);
        check("t2_ins1",   bus.out_ins1,        32'd0);
        check("t2_count",  32'(bus.count),      32'd1);
        tick();
        check("t2b_ins0",  bus.out_ins0,        ADD_6_3_1);
        check("t2b_pc0",   bus.out_pc0,         32'h21);
        check("t2b_valid1", 32'(bus.out_valid1), 32'd0);
        check("t2b_count", 32'(bus.count),      32'd0);

        // control instruction issues alone, then flush discards everything
        drive_pair(BEQ_1_2, ADD_5_4_6, 32'h30);
        tick();
        drive_idle();
        tick();
        check("t3_ins0",   bus.out_ins0,        BEQ_1_2);
        check("t3_valid1", 32'(bus.out_valid1), 32'd0);
        check("t3_count",  32'(bus.count),      32'd1);
        bus.flush = 1'b1;
        drive_pair(ADD_3_1_2, ADD_5_4_6, 32'h40);
        tick();
        bus.flush = 1'b0;
        drive_idle();
        check("t3_fl_count",  32'(bus.count),      32'd0);
        check("t3_fl_valid0", 32'(bus.out_valid0), 32'd0);
        check("t3_fl_valid1", 32'(bus.out_valid1), 32'd0);
        check("t3_fl_pc0",    bus.out_pc0,         32'd0);
        tick();
        check("t3_wrongpath_count",  32'(bus.count),      32'd0);
        check("t3_wrongpath_valid0", 32'(bus.out_valid0), 32'd0);

        // back-pressure: stalled consumer, continuous fetch
        bus.out_ready = 1'b0;
        for (int k = 0; k < 5; k++) begin
            drive_pair(ADD_3_1_2, ADD_5_4_6, 32'h100 + 32'(2 * k));
            tick();
        end
        check("t4_count8",    32'(bus.count),      32'd8);
        check("t4_in_ready",  32'(bus.in_ready),   32'd0);
        check("t4_hold_pc0",  bus.out_pc0,         32'h100);
        check("t4_hold_pc1",  bus.out_pc1,         32'h101);
        drive_pair(ADD_3_1_2, ADD_5_4_6, 32'h1F0);
        tick();
        check("t4_overflow",  32'(bus.overflow),   32'd1);
        check("t4_count_kept", 32'(bus.count),     32'd8);
        drive_idle();
        bus.out_ready = 1'b1;
        tick();
        check("t4_drain_count", 32'(bus.count),    32'd6);
        check("t4_drain_pc0",   bus.out_pc0,       32'h102);
        check("t4_in_ready6",   32'(bus.in_ready), 32'd1);

        // reset mid-state: 6 queued, lane 0 occupied, overflow set
        bus.out_ready = 1'b0;
        rst = 1'b0;
        tick();
        rst = 1'b1;
        check("t6_count",    32'(bus.count),      32'd0);
        check("t6_valid0",   32'(bus.out_valid0), 32'd0);
        check("t6_valid1",   32'(bus.out_valid1), 32'd0);
        check("t6_ins0",     bus.out_ins0,        32'd0);
        check("t6_pc0",      bus.out_pc0,         32'd0);
        check("t6_pc1",      bus.out_pc1,         32'd0);
        check("t6_overflow", 32'(bus.overflow),   32'd0);
        check("t6_in_ready", 32'(bus.in_ready),   32'd1);

        // 20 independent pairs, full rate, pointers wrap several times
        bus.out_ready = 1'b1;
        for (int k = 0; k < 20; k++) begin
            drive_pair(ADD_3_1_2, ADD_5_4_6, 32'h200 + 32'(2 * k));
            if (bus.in_ready !== 1'b1) check("t5_in_ready", 32'(bus.in_ready), 32'd1);
            exp_q.push_back({ADD_3_1_2, 32'h200 + 32'(2 * k)});
            exp_q.push_back({ADD_5_4_6, 32'h200 + 32'(2 * k + 1)});
            tick();
            consume_lane("t5_lane0", bus.out_valid0, bus.out_ins0, bus.out_pc0);
            consume_lane("t5_lane1", bus.out_valid1, bus.out_ins1, bus.out_pc1);
        end
        drive_idle();
        for (int c = 0; c < 8 && exp_q.size() != 0; c++) begin
            tick();
            consume_lane("t5_lane0", bus.out_valid0, bus.out_ins0, bus.out_pc0);
            consume_lane("t5_lane1", bus.out_valid1, bus.out_ins1, bus.out_pc1);
        end
        check("t5_lost_entries", 32'(exp_q.size()), 32'd0);
        check("t5_final_count",  32'(bus.count),    32'd0);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end
endmodule
